// File: rtl/msrh_pkg.sv
// rtl/msrh_pkg.sv - shared types, constants and counter helper for the BIM updater
// Purpose: default geometry of the bimodal table, FSM state encoding, the
//          weakly-not-taken init value and the 2-bit saturating counter update.
// Ports:   none (package)
package msrh_pkg;

    localparam int BIM_IDX_W_DEF = 10;
    localparam int IDX_LSB_DEF   = 1;
    localparam int VADDR_W_DEF   = 39;

    typedef logic [BIM_IDX_W_DEF-1:0] bim_idx_t;

    localparam logic [1:0] BIM_INIT_VAL = 2'b01;

    typedef enum logic {
        BIM_INIT = 1'b0,
        BIM_RUN  = 1'b1
    } bim_state_t;

    function automatic logic [1:0] bim_sat_update(logic [1:0] cnt, logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/msrh_ram_2r1w.sv
// rtl/msrh_ram_2r1w.sv - two synchronous read ports, one write port, no reset
// Purpose: storage array for the BIM counters. Reads are registered and return
//          the contents before a same-edge write (read-old); any write-first
//          behaviour is provided by the user of this array.
// Ports:   clk                     clock
//          rd_a_addr / rd_a_data   read port A (address in, data next cycle)
//          rd_b_addr / rd_b_data   read port B (address in, data next cycle)
//          wr_en, wr_addr, wr_data write port
module msrh_ram_2r1w #(
    parameter int WORDS = 1024,
    parameter int WIDTH = 2,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_a_data <= mem[rd_a_addr];
        rd_b_data <= mem[rd_b_addr];
    end

endmodule

// File: rtl/msrh_bim_updater.sv
// rtl/msrh_bim_updater.sv - bimodal counter table with in-order training and lookup
// Purpose: clears the table with a sweep after reset, then applies one
//          resolved conditional-branch update per cycle through a two-stage
//          read-modify-write and serves one-cycle-latency prediction reads.
// Ports:   i_clk, i_reset                 clock, synchronous active-high reset
//          i_upd_valid/is_cond/dead/taken update qualifiers and direction
//          i_upd_pc_vaddr                 branch pc to train
//          i_rd_valid, i_rd_pc_vaddr      lookup request
//          o_rd_valid, o_rd_bim_value     lookup result, one cycle later
//          o_init_done                    sweep complete
//          o_upd_applied                  a training write happened this cycle
module msrh_bim_updater
    import msrh_pkg::*;
#(
    parameter int BIM_IDX_W = BIM_IDX_W_DEF,
    parameter int IDX_LSB   = IDX_LSB_DEF,
    parameter int VADDR_W   = VADDR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_upd_valid,
    input  logic               i_upd_is_cond,
    input  logic               i_upd_dead,
    input  logic               i_upd_taken,
    input  logic [VADDR_W-1:0] i_upd_pc_vaddr,
    input  logic               i_rd_valid,
    input  logic [VADDR_W-1:0] i_rd_pc_vaddr,
    output logic               o_rd_valid,
    output logic [1:0]         o_rd_bim_value,
    output logic               o_init_done,
    output logic               o_upd_applied
);

    localparam int WORDS = 1 << BIM_IDX_W;
    localparam logic [BIM_IDX_W-1:0] SWEEP_LAST = '1;

    bim_state_t           state;
    bim_state_t           next_state;
    logic [BIM_IDX_W-1:0] sweep_idx;

    logic [BIM_IDX_W-1:0] upd_idx;
    logic [BIM_IDX_W-1:0] rd_idx;
    logic                 upd_accept;

    // Second stage of the update pipeline (the write stage).
    logic                 u2_valid;
    logic [BIM_IDX_W-1:0] u2_idx;
    logic                 u2_taken;
    logic                 u2_byp;
    logic [1:0]           u2_byp_val;
    logic [1:0]           u2_old;
    logic [1:0]           u2_new;

    logic                 wr_en;
    logic [BIM_IDX_W-1:0] wr_idx;
    logic [1:0]           wr_data;

    logic [1:0]           ram_a_data;
    logic [1:0]           ram_b_data;

    logic                 rd_in_init;
    logic                 rd_byp;
    logic [1:0]           rd_byp_val;

    logic                 unused_pc;

    // Upper pc bits alias onto the same counter by design.
    assign unused_pc = ^{i_upd_pc_vaddr, i_rd_pc_vaddr};

    assign upd_idx = i_upd_pc_vaddr[IDX_LSB +: BIM_IDX_W];
    assign rd_idx  = i_rd_pc_vaddr[IDX_LSB +: BIM_IDX_W];

    assign upd_accept = i_upd_valid & i_upd_is_cond & ~i_upd_dead & (state == BIM_RUN);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= BIM_INIT;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            BIM_INIT: if (sweep_idx == SWEEP_LAST) next_state = BIM_RUN;
            BIM_RUN:  next_state = BIM_RUN;
            default:  next_state = BIM_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)                sweep_idx <= '0;
        else if (state == BIM_INIT) sweep_idx <= sweep_idx + 1'b1;
    end

    assign o_init_done = (state == BIM_RUN);

    // ------------------------------------------------------ update pipeline
    // The array read for an accepted update lands next cycle. If the write
    // stage is updating the same entry in the accept cycle, the array read
    // returns the stale value, so the freshly computed one is captured here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            u2_valid   <= 1'b0;
            u2_idx     <= '0;
            u2_taken   <= 1'b0;
            u2_byp     <= 1'b0;
            u2_byp_val <= 2'b00;
        end else begin
            u2_valid   <= upd_accept;
            u2_idx     <= upd_idx;
            u2_taken   <= i_upd_taken;
            u2_byp     <= u2_valid && (u2_idx == upd_idx);
            u2_byp_val <= u2_new;
        end
    end

    assign u2_old = u2_byp ? u2_byp_val : ram_b_data;
    assign u2_new = bim_sat_update(u2_old, u2_taken);

    // The sweep and the training writes never overlap: training is only
    // accepted in RUN, and RUN is left only through reset. Writes are
    // suppressed while reset is held so an in-flight update is discarded.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = u2_idx;
        wr_data = u2_new;
        if (!i_reset) begin
            if (state == BIM_INIT) begin
                wr_en   = 1'b1;
                wr_idx  = sweep_idx;
                wr_data = BIM_INIT_VAL;
            end else if (u2_valid) begin
                wr_en = 1'b1;
            end
        end
    end

    assign o_upd_applied = u2_valid & ~i_reset;

    // ---------------------------------------------------------------- lookup
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_valid <= 1'b0;
            rd_in_init <= 1'b0;
            rd_byp     <= 1'b0;
            rd_byp_val <= 2'b00;
        end else begin
            o_rd_valid <= i_rd_valid;
            rd_in_init <= (state == BIM_INIT);
            rd_byp     <= wr_en && (wr_idx == rd_idx);
            rd_byp_val <= wr_data;
        end
    end

    always_comb begin
        o_rd_bim_value = 2'b00;
        if (o_rd_valid) begin
            if (rd_in_init)  o_rd_bim_value = BIM_INIT_VAL;
            else if (rd_byp) o_rd_bim_value = rd_byp_val;
            else             o_rd_bim_value = ram_a_data;
        end
    end

    msrh_ram_2r1w #(
        .WORDS (WORDS),
        .WIDTH (2),
        .AW    (BIM_IDX_W)
    ) u_ram (
        .clk       (i_clk),
        .rd_a_addr (rd_idx),
        .rd_a_data (ram_a_data),
        .rd_b_addr (upd_idx),
        .rd_b_data (ram_b_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_idx),
        .wr_data   (wr_data)
    );

endmodule
